// File: rtl/spart_pkg.sv
// Shared SPART definitions: sequencer states, register addresses
// and default baud divisors (50 MHz clock).
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_RD,
    TX_WR,
    TX_HOLD
  } state_t;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam logic [15:0] DEF_DIV0 = 16'h028A;
  localparam logic [15:0] DEF_DIV1 = 16'h0144;
  localparam logic [15:0] DEF_DIV2 = 16'h00A1;
  localparam logic [15:0] DEF_DIV3 = 16'h0050;

endpackage

// File: rtl/spart_bus_sequencer_arb.sv
// Round-robin arbiter: search starts one past the last winner.
// Pointer only moves when the caller commits a grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [W-1:0]       winner,
  output logic               valid
);

  logic [W-1:0] ptr;

  function automatic logic [W-1:0] wrap_add(
    input logic [W-1:0] p,
    input int unsigned  k
  );
    logic [W:0] s;
    s = {1'b0, p} + (W+1)'(k);
    if (s >= (W+1)'(NUM_REQ))
      s = s - (W+1)'(NUM_REQ);
    return s[W-1:0];
  endfunction

  // Walk downward so the nearest requester overwrites the rest.
  always_comb begin
    winner = ptr;
    valid  = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[wrap_add(ptr, unsigned'(i))])
        winner = wrap_add(ptr, unsigned'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= W'(NUM_REQ - 1);
    else if (en)
      ptr <= winner;
  end

endmodule

// File: rtl/spart_bus_sequencer.sv
// SPART bus master: baud config, receive drain and
// round-robin transmit scheduling. All outputs registered.
module spart_bus_sequencer
  import spart_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] DIV0    = DEF_DIV0,
  parameter logic [15:0] DIV1    = DEF_DIV1,
  parameter logic [15:0] DIV2    = DEF_DIV2,
  parameter logic [15:0] DIV3    = DEF_DIV3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           br_cfg,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic                 cfg_done,
  output logic                 iocs,
  output logic                 iorw,
  output logic [1:0]           ioaddr,
  output logic [7:0]           spart_dout,
  output logic                 spart_oe,
  input  logic [7:0]           spart_din,
  input  logic                 rda,
  input  logic                 tbr
);

  localparam int W = $clog2(NUM_REQ);

  state_t       state, next_state;
  logic [1:0]   cfg_q;
  logic         hold_q;
  logic [W-1:0] winner;
  logic         arb_valid;
  logic         arb_en;
  logic [7:0]   tx_byte;
  logic [15:0]  div_new, div_cur;

  logic               iocs_d, iorw_d, oe_d;
  logic [1:0]         ioaddr_d;
  logic [7:0]         dout_d, rx_data_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               rx_valid_d, cfg_done_d;

  function automatic logic [15:0] div_of(input logic [1:0] s);
    logic [15:0] d;
    unique case (s)
      2'd0:    d = DIV0;
      2'd1:    d = DIV1;
      2'd2:    d = DIV2;
      default: d = DIV3;
    endcase
    return d;
  endfunction

  assign div_new = div_of(br_cfg);
  assign div_cur = div_of(cfg_q);
  assign arb_en  = (state == IDLE) && (next_state == TX_WR);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (arb_en),
    .winner(winner),
    .valid (arb_valid)
  );

  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == W'(i))
        tx_byte = req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= CFG_LO;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      CFG_LO:  next_state = CFG_HI;
      CFG_HI:  next_state = IDLE;
      IDLE: begin
        if (br_cfg != cfg_q)
          next_state = CFG_LO;
        else if (rda)
          next_state = RX_RD;
        else if (tbr && arb_valid)
          next_state = TX_WR;
      end
      RX_RD:   next_state = IDLE;
      TX_WR:   next_state = TX_HOLD;
      TX_HOLD: if (hold_q) next_state = IDLE;
      default: next_state = CFG_LO;
    endcase
  end

  // Bus cycles are registered on the edge leaving the deciding state.
  always_comb begin
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    oe_d       = 1'b0;
    ioaddr_d   = ioaddr;
    dout_d     = spart_dout;
    gnt_d      = '0;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    cfg_done_d = cfg_done;
    unique case (state)
      CFG_LO: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        oe_d       = 1'b1;
        ioaddr_d   = ADDR_DBL;
        dout_d     = div_new[7:0];
        cfg_done_d = 1'b0;
      end
      CFG_HI: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        oe_d       = 1'b1;
        ioaddr_d   = ADDR_DBH;
        dout_d     = div_cur[15:8];
        cfg_done_d = 1'b1;
      end
      IDLE: begin
        if (next_state == CFG_LO) begin
          cfg_done_d = 1'b0;
        end else if (next_state == RX_RD) begin
          iocs_d   = 1'b1;
          ioaddr_d = ADDR_BUF;
        end else if (next_state == TX_WR) begin
          iocs_d   = 1'b1;
          iorw_d   = 1'b0;
          oe_d     = 1'b1;
          ioaddr_d = ADDR_BUF;
          dout_d   = tx_byte;
          gnt_d    = NUM_REQ'(1) << winner;
        end
      end
      RX_RD: begin
        rx_data_d  = spart_din;
        rx_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iocs       <= 1'b0;
      iorw       <= 1'b1;
      spart_oe   <= 1'b0;
      ioaddr     <= ADDR_BUF;
      spart_dout <= 8'h00;
      gnt        <= '0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_q      <= 2'b00;
      hold_q     <= 1'b0;
    end else begin
      iocs       <= iocs_d;
      iorw       <= iorw_d;
      spart_oe   <= oe_d;
      ioaddr     <= ioaddr_d;
      spart_dout <= dout_d;
      gnt        <= gnt_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      cfg_done   <= cfg_done_d;
      hold_q     <= (state == TX_HOLD) && !hold_q;
      if (state == CFG_LO)
        cfg_q <= br_cfg;
    end
  end

endmodule

// File: tb/tb_spart_bus_sequencer.sv
// Directed bench for spart_bus_sequencer: config, round-robin
// transmit, receive priority, reconfig and mid-transfer reset.
module tb_spart_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  br_cfg;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cfg_done;
  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  spart_dout;
  logic        spart_oe;
  logic [7:0]  spart_din;
  logic        rda;
  logic        tbr;

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_tab [4];

  always #5 clk = ~clk;

  spart_bus_sequencer #(
    .NUM_REQ(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cfg_done  (cfg_done),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .spart_dout(spart_dout),
    .spart_oe  (spart_oe),
    .spart_din (spart_din),
    .rda       (rda),
    .tbr       (tbr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag,
                        input logic [1:0] a,
                        input logic [7:0] d);
    chk({tag, ".iocs"}, 32'(iocs), 32'd1);
    chk({tag, ".iorw"}, 32'(iorw), 32'd0);
    chk({tag, ".oe"}, 32'(spart_oe), 32'd1);
    chk({tag, ".addr"}, 32'(ioaddr), 32'(a));
    chk({tag, ".dout"}, 32'(spart_dout), 32'(d));
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, ".iocs"}, 32'(iocs), 32'd0);
    chk({tag, ".iorw"}, 32'(iorw), 32'd1);
    chk({tag, ".oe"}, 32'(spart_oe), 32'd0);
  endtask

  initial begin
    byte_tab[0] = 8'hA0;
    byte_tab[1] = 8'hB1;
    byte_tab[2] = 8'hC2;
    byte_tab[3] = 8'hD3;
    rst       = 1'b1;
    br_cfg    = 2'd1;
    req       = 4'b0000;
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    spart_din = 8'h00;
    rda       = 1'b0;
    tbr       = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle_bus("rst");
    chk("rst.addr", 32'(ioaddr), 32'd0);
    chk("rst.dout", 32'(spart_dout), 32'h00);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.rx_data", 32'(rx_data), 32'h00);
    chk("rst.rx_valid", 32'(rx_valid), 32'd0);
    chk("rst.cfg_done", 32'(cfg_done), 32'd0);

    // Release: divisor 0x0144 goes out low byte then high byte.
    rst = 1'b0;
    @(negedge clk);
    chk_wr("cfg1.lo", 2'b10, 8'h44);
    chk("cfg1.lo.done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    chk_wr("cfg1.hi", 2'b11, 8'h01);
    chk("cfg1.hi.done", 32'(cfg_done), 32'd1);
    @(negedge clk);
    chk_idle_bus("cfg1.after");
    chk("cfg1.after.dout", 32'(spart_dout), 32'h01);

    // All four requesters held: grants 0,1,2,3,0 four cycles apart.
    req = 4'b1111;
    tbr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (3) @(negedge clk);
      else @(negedge clk);
      chk($sformatf("rr%0d.gnt", k), 32'(gnt), 32'd1 << (k % 4));
      chk_wr($sformatf("rr%0d", k), 2'b00, byte_tab[k % 4]);
      @(negedge clk);
      chk($sformatf("rr%0d.hold.gnt", k), 32'(gnt), 32'd0);
      chk($sformatf("rr%0d.hold.iocs", k), 32'(iocs), 32'd0);
      chk($sformatf("rr%0d.hold.dout", k), 32'(spart_dout),
          32'(byte_tab[k % 4]));
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // rda and req[2] together: read first, then grant.
    rda       = 1'b1;
    req       = 4'b0100;
    spart_din = 8'h5A;
    @(negedge clk);
    chk("rx.rd.iocs", 32'(iocs), 32'd1);
    chk("rx.rd.iorw", 32'(iorw), 32'd1);
    chk("rx.rd.oe", 32'(spart_oe), 32'd0);
    chk("rx.rd.addr", 32'(ioaddr), 32'd0);
    chk("rx.rd.gnt", 32'(gnt), 32'd0);
    rda = 1'b0;
    @(negedge clk);
    chk("rx.valid", 32'(rx_valid), 32'd1);
    chk("rx.data", 32'(rx_data), 32'h5A);
    chk("rx.valid.gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("rx.tx.gnt", 32'(gnt), 32'b0100);
    chk("rx.tx.dout", 32'(spart_dout), 32'hC2);
    chk("rx.valid.drop", 32'(rx_valid), 32'd0);
    chk("rx.data.hold", 32'(rx_data), 32'h5A);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // br_cfg change during TX_HOLD: transmit finishes, then reconfig.
    req = 4'b0010;
    @(negedge clk);
    chk("rc.gnt", 32'(gnt), 32'b0010);
    chk_wr("rc.tx", 2'b00, 8'hB1);
    req = 4'b0000;
    @(negedge clk);
    br_cfg = 2'd3;
    repeat (2) @(negedge clk);
    chk("rc.idle.done", 32'(cfg_done), 32'd1);
    @(negedge clk);
    chk("rc.clr.done", 32'(cfg_done), 32'd0);
    chk("rc.clr.iocs", 32'(iocs), 32'd0);
    @(negedge clk);
    chk_wr("rc.lo", 2'b10, 8'h50);
    chk("rc.lo.done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    chk_wr("rc.hi", 2'b11, 8'h00);
    chk("rc.hi.done", 32'(cfg_done), 32'd1);

    // tbr low blocks transmit; same requester may win back-to-back.
    tbr = 1'b0;
    req = 4'b0010;
    @(negedge clk);
    chk("tbr0.a.iocs", 32'(iocs), 32'd0);
    chk("tbr0.a.gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("tbr0.b.iocs", 32'(iocs), 32'd0);
    chk("tbr0.b.gnt", 32'(gnt), 32'd0);
    tbr = 1'b1;
    @(negedge clk);
    chk("tbr1.gnt", 32'(gnt), 32'b0010);
    chk("tbr1.dout", 32'(spart_dout), 32'hB1);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset hits just after the TX_WR edge.
    req = 4'b1000;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.gnt", 32'(gnt), 32'd0);
    chk_idle_bus("arst");
    chk("arst.addr", 32'(ioaddr), 32'd0);
    chk("arst.dout", 32'(spart_dout), 32'h00);
    chk("arst.rx_data", 32'(rx_data), 32'h00);
    chk("arst.done", 32'(cfg_done), 32'd0);
    repeat (2) @(negedge clk);
    chk("arst.held.gnt", 32'(gnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_wr("arst.cfg.lo", 2'b10, 8'h50);
    @(negedge clk);
    chk_wr("arst.cfg.hi", 2'b11, 8'h00);
    chk("arst.cfg.done", 32'(cfg_done), 32'd1);
    @(negedge clk);
    chk("arst.ptr.gnt", 32'(gnt), 32'b1000);
    chk("arst.ptr.dout", 32'(spart_dout), 32'hD3);
    req = 4'b0000;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
